// File: rtl/encapsulate_pkt_mc.sv
// encapsulate_pkt_mc
//   Multi-channel packet encapsulator for the router send path. It takes
//   data requests from NUM_CH lane send controllers and ACK-only requests
//   from the receive side. ACKs always win. Data channels share the output
//   in round-robin order. The header fields are attached and the packet is
//   presented to the fragmenter through a single holding register.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   local_dfx      source node id stamped into every packet (static)
//   in_valid       per-channel data request valid
//   in_ready       per-channel accept (combinational, one-hot or zero)
//   in_data        per-channel payload; channel i at slice i
//   in_dst         per-channel destination
//   in_replay      per-channel replay flag
//   in_replay_sn   per-channel sequence number used on replay
//   ack_req        ACK packet requested (level, held until ack_ready)
//   ack_dst        ACK destination
//   ack_sn         sequence number being acknowledged
//   ack_ready      ACK request accepted (combinational)
//   pkt_valid      packet valid
//   pkt_ready      fragmenter accepts packet
//   pkt_data       {payload, ack, rn, sn, ack_sn, dst, src}; src in the LSBs
//   pkt_ch         originating channel; 0 for ACK packets
//   sn_next        next fresh sequence number per channel
module encapsulate_pkt_mc #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int SEQ_NUM_WIDTH  = 2,
  parameter int DFX_WIDTH      = 2,
  parameter int NUM_CH         = 4,
  parameter int CH_ID_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PKT_WIDTH      = DATA_DFX_WIDTH + 2 + 2*SEQ_NUM_WIDTH + 2*DFX_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DFX_WIDTH-1:0]               local_dfx,
  input  logic [NUM_CH-1:0]                  in_valid,
  output logic [NUM_CH-1:0]                  in_ready,
  input  logic [NUM_CH*DATA_DFX_WIDTH-1:0]   in_data,
  input  logic [NUM_CH*DFX_WIDTH-1:0]        in_dst,
  input  logic [NUM_CH-1:0]                  in_replay,
  input  logic [NUM_CH*SEQ_NUM_WIDTH-1:0]    in_replay_sn,
  input  logic                               ack_req,
  input  logic [DFX_WIDTH-1:0]               ack_dst,
  input  logic [SEQ_NUM_WIDTH-1:0]           ack_sn,
  output logic                               ack_ready,
  output logic                               pkt_valid,
  input  logic                               pkt_ready,
  output logic [PKT_WIDTH-1:0]               pkt_data,
  output logic [CH_ID_WIDTH-1:0]             pkt_ch,
  output logic [NUM_CH*SEQ_NUM_WIDTH-1:0]    sn_next
);

  logic                                   pkt_valid_q, pkt_valid_d;
  logic [PKT_WIDTH-1:0]                   pkt_data_q, pkt_data_d;
  logic [CH_ID_WIDTH-1:0]                 pkt_ch_q, pkt_ch_d;
  logic [CH_ID_WIDTH-1:0]                 rr_q, rr_d;
  logic [NUM_CH-1:0][SEQ_NUM_WIDTH-1:0]   sn_cnt_q, sn_cnt_d;

  logic                                   load_en;
  logic                                   gnt_found;
  logic [CH_ID_WIDTH-1:0]                 gnt_ch;
  logic                                   gnt_rn;
  logic [SEQ_NUM_WIDTH-1:0]               gnt_sn;

  assign load_en = !pkt_valid_q || pkt_ready;

  // Round-robin search: first valid channel at or after the pointer.
  always_comb begin
    int                     idx;
    logic [CH_ID_WIDTH-1:0] idx_c;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    idx_c     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_ID_WIDTH'(idx);
      if (!gnt_found && in_valid[idx_c]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx_c;
      end
    end
  end

  // Replays reuse the caller's number; fresh packets take the channel counter.
  always_comb begin
    gnt_rn = in_replay[gnt_ch];
    gnt_sn = gnt_rn ? in_replay_sn[int'(gnt_ch)*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH]
                    : sn_cnt_q[gnt_ch];
  end

  always_comb begin
    in_ready    = '0;
    ack_ready   = 1'b0;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    pkt_ch_d    = pkt_ch_q;
    rr_d        = rr_q;
    sn_cnt_d    = sn_cnt_q;
    if (load_en) begin
      pkt_valid_d = 1'b0;
      if (ack_req) begin
        ack_ready   = 1'b1;
        pkt_valid_d = 1'b1;
        pkt_data_d  = {{DATA_DFX_WIDTH{1'b0}}, 1'b1, 1'b0, {SEQ_NUM_WIDTH{1'b0}},
                       ack_sn, ack_dst, local_dfx};
        pkt_ch_d    = '0;
      end else if (gnt_found) begin
        in_ready[gnt_ch] = 1'b1;
        pkt_valid_d      = 1'b1;
        pkt_data_d       = {in_data[int'(gnt_ch)*DATA_DFX_WIDTH +: DATA_DFX_WIDTH],
                            1'b0, gnt_rn, gnt_sn, {SEQ_NUM_WIDTH{1'b0}},
                            in_dst[int'(gnt_ch)*DFX_WIDTH +: DFX_WIDTH], local_dfx};
        pkt_ch_d         = gnt_ch;
        if (!gnt_rn) sn_cnt_d[gnt_ch] = sn_cnt_q[gnt_ch] + SEQ_NUM_WIDTH'(1);
        rr_d = (gnt_ch == CH_ID_WIDTH'(NUM_CH - 1)) ? '0 : gnt_ch + CH_ID_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      pkt_ch_q    <= '0;
      rr_q        <= '0;
      sn_cnt_q    <= '0;
    end else begin
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      pkt_ch_q    <= pkt_ch_d;
      rr_q        <= rr_d;
      sn_cnt_q    <= sn_cnt_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_ch    = pkt_ch_q;
  assign sn_next   = sn_cnt_q;

endmodule

// File: tb/tb_encapsulate_pkt_mc.sv
// Testbench for encapsulate_pkt_mc: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter,
// sequence counters and output holding register.
module tb_encapsulate_pkt_mc;

  localparam int DDW = 1034;
  localparam int NCH = 4;
  localparam int PW  = DDW + 2 + 4 + 4;
  localparam int NW  = (DDW + 31) / 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           local_dfx;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*DDW-1:0]   in_data;
  logic [NCH*2-1:0]     in_dst;
  logic [NCH-1:0]       in_replay;
  logic [NCH*2-1:0]     in_replay_sn;
  logic                 ack_req;
  logic [1:0]           ack_dst;
  logic [1:0]           ack_sn;
  logic                 ack_ready;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [PW-1:0]        pkt_data;
  logic [1:0]           pkt_ch;
  logic [NCH*2-1:0]     sn_next;

  encapsulate_pkt_mc dut (
    .clk(clk), .rst_n(rst_n), .local_dfx(local_dfx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dst(in_dst), .in_replay(in_replay), .in_replay_sn(in_replay_sn),
    .ack_req(ack_req), .ack_dst(ack_dst), .ack_sn(ack_sn), .ack_ready(ack_ready),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .pkt_ch(pkt_ch), .sn_next(sn_next)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit            m_valid;
  logic [PW-1:0] m_pkt;
  int            m_ch;
  int            m_rr;
  int            m_sn [NCH];
  bit            m_ack_taken;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [DDW-1:0] pay, input logic ack,
                                       input logic rn, input logic [1:0] sn,
                                       input logic [1:0] asn, input logic [1:0] dst,
                                       input logic [1:0] src);
    return {pay, ack, rn, sn, asn, dst, src};
  endfunction

  function automatic int pick();
    for (int d = 0; d < NCH; d++) begin
      int c;
      c = (m_rr + d) % NCH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pkt = '0; m_ch = 0; m_rr = 0; m_ack_taken = 0;
    for (int c = 0; c < NCH; c++) m_sn[c] = 0;
  endtask

  task automatic fill_payload();
    for (int c = 0; c < NCH; c++) begin
      logic [DDW-1:0] p;
      p = '0;
      for (int w = 0; w < NW; w++) p = {p[DDW-33:0], $urandom};
      in_data[c*DDW +: DDW] = p;
    end
  endtask

  task automatic check_out();
    logic [DDW-1:0] gp, ep;
    chk("pkt_valid", 64'(pkt_valid), 64'(m_valid));
    if (m_valid) begin
      chk("hdr", 64'(pkt_data[9:0]), 64'(m_pkt[9:0]));
      chk("pkt_ch", 64'(pkt_ch), 64'(m_ch));
      gp = pkt_data[PW-1:10];
      ep = m_pkt[PW-1:10];
      for (int w = 0; w < NW; w++)
        chk("payload", 64'(32'(gp >> (32*w))), 64'(32'(ep >> (32*w))));
    end
    for (int c = 0; c < NCH; c++)
      chk("sn_next", 64'(sn_next[c*2 +: 2]), 64'(m_sn[c]));
  endtask

  // One clock: check the combinational accepts, advance model at the edge,
  // then check the registered outputs.
  task automatic step();
    bit             load;
    int             g;
    logic [NCH-1:0] exp_rdy;
    logic           rn;
    logic [1:0]     sn;
    #1;
    load    = !m_valid || pkt_ready;
    g       = pick();
    exp_rdy = '0;
    if (load && !ack_req && g >= 0) exp_rdy[g] = 1'b1;
    m_ack_taken = load && ack_req;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("ack_ready", 64'(ack_ready), 64'(m_ack_taken));
    @(posedge clk);
    if (load) begin
      m_valid = 0;
      if (ack_req) begin
        m_valid = 1;
        m_pkt   = mk('0, 1'b1, 1'b0, 2'd0, ack_sn, ack_dst, local_dfx);
        m_ch    = 0;
      end else if (g >= 0) begin
        rn      = in_replay[g];
        sn      = rn ? in_replay_sn[g*2 +: 2] : 2'(m_sn[g]);
        m_pkt   = mk(in_data[g*DDW +: DDW], 1'b0, rn, sn, 2'd0, in_dst[g*2 +: 2], local_dfx);
        m_ch    = g;
        m_valid = 1;
        if (!rn) m_sn[g] = (m_sn[g] + 1) % 4;
        m_rr = (g + 1) % NCH;
      end
    end
    #1;
    check_out();
  endtask

  initial begin
    logic [PW-1:0] hold;
    rst_n = 1'b0;
    local_dfx = 2'd1;
    in_valid = '0; in_data = '0; in_dst = '0; in_replay = '0; in_replay_sn = '0;
    ack_req = 0; ack_dst = 0; ack_sn = 0; pkt_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_data_nz", 64'(|pkt_data), 64'd0);
    chk("rst_ch", 64'(pkt_ch), 64'd0);
    chk("rst_sn_next", 64'(sn_next), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on ch0
    in_data[0 +: DDW] = DDW'(8'h5A);
    in_dst[1:0] = 2'd2;
    in_valid = 4'b0001;
    step();
    chk("t1_valid", 64'(pkt_valid), 64'd1);
    chk("t1_sn", 64'(pkt_data[7:6]), 64'd0);
    chk("t1_rn", 64'(pkt_data[8]), 64'd0);
    chk("t1_ack", 64'(pkt_data[9]), 64'd0);
    chk("t1_dst", 64'(pkt_data[3:2]), 64'd2);
    chk("t1_src", 64'(pkt_data[1:0]), 64'd1);
    chk("t1_ch", 64'(pkt_ch), 64'd0);
    chk("t1_pay", 64'(pkt_data[PW-1:10]), 64'h5A);
    step();
    chk("t1_sn2", 64'(pkt_data[7:6]), 64'd1);
    in_valid = '0;
    step();

    // ch1 and ch3 continuously requesting
    in_valid = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      fill_payload();
      in_dst = 8'($urandom);
      step();
      chk("alt_ch", 64'(pkt_ch), (i % 2) ? 64'd3 : 64'd1);
      chk("alt_sn", 64'(pkt_data[7:6]), 64'((i / 2) % 4));
    end

    // Stall with ch2 waiting
    in_valid = 4'b0100;
    pkt_ready = 1'b0;
    hold = pkt_data;
    for (int i = 0; i < 5; i++) begin
      fill_payload();
      step();
      chk("stall_stable", 64'(pkt_data !== hold), 64'd0);
      chk("stall_rdy", 64'(in_ready), 64'd0);
    end
    pkt_ready = 1'b1;
    step();
    chk("stall_ch", 64'(pkt_ch), 64'd2);
    in_valid = '0;

    // ACK beats a simultaneous data request
    in_valid = 4'b0001;
    ack_req = 1'b1; ack_dst = 2'd3; ack_sn = 2'd2;
    step();
    chk("ack_flag", 64'(pkt_data[9]), 64'd1);
    chk("ack_asn", 64'(pkt_data[5:4]), 64'd2);
    chk("ack_dst", 64'(pkt_data[3:2]), 64'd3);
    chk("ack_pay_nz", 64'(|pkt_data[PW-1:10]), 64'd0);
    ack_req = 1'b0;
    step();
    chk("post_ack_ch", 64'(pkt_ch), 64'd0);
    chk("post_ack_flag", 64'(pkt_data[9]), 64'd0);
    in_valid = '0;

    // Reset while a packet is held
    in_valid = 4'b0010;
    pkt_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(pkt_valid), 64'd0);
    chk("mid_rst_data_nz", 64'(|pkt_data), 64'd0);
    model_reset();
    in_valid = '0;
    pkt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_sn_next", 64'(sn_next), 64'd0);

    // Replay on ch2 after two fresh packets
    in_valid = 4'b0100;
    step();
    chk("rp_sn0", 64'(pkt_data[7:6]), 64'd0);
    step();
    chk("rp_sn1", 64'(pkt_data[7:6]), 64'd1);
    in_replay = 4'b0100;
    in_replay_sn = 8'b00_01_00_00;
    step();
    chk("rp_rn", 64'(pkt_data[8]), 64'd1);
    chk("rp_sn", 64'(pkt_data[7:6]), 64'd1);
    in_replay = '0;
    step();
    chk("rp_fresh_rn", 64'(pkt_data[8]), 64'd0);
    chk("rp_fresh_sn", 64'(pkt_data[7:6]), 64'd2);
    in_valid = '0;
    step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid     = 4'($urandom);
      in_replay    = 4'($urandom) & 4'($urandom);
      in_replay_sn = 8'($urandom);
      in_dst       = 8'($urandom);
      fill_payload();
      pkt_ready    = ($urandom % 4) != 0;
      if (!ack_req || m_ack_taken) begin
        ack_req = ($urandom % 5) == 0;
        ack_dst = 2'($urandom);
        ack_sn  = 2'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/encapsulate_pkt_mc.md
Name: encapsulate_pkt_mc

Overview:
- Multi-channel packet encapsulator for the 4-lane router's send path.
- Takes DFX data requests from NUM_CH lane send controllers plus ACK-only requests from the receive side, and arbitrates between them.
- Attaches header fields: ack flag, replay flag, sequence number, acked sequence number, destination, source.
- Presents one packet at a time to the fragmenter on a valid/ready interface.
- Per-channel sequence numbers are generated internally; replayed packets reuse a caller-supplied number.

Parameters:
- DATA_WIDTH, 1024, payload data width.
- ADDR_WIDTH, 10, DFX address width.
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, payload field width.
- SEQ_NUM_WIDTH, 2, sequence number width.
- DFX_WIDTH, 2, DFX node id width.
- NUM_CH, 4, number of data request channels (NUM_CH ≥ 1).
- CH_ID_WIDTH, clog2(NUM_CH) (minimum 1), channel index width.
- PKT_WIDTH, DATA_DFX_WIDTH+2+2*SEQ_NUM_WIDTH+2*DFX_WIDTH, packet width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- local_dfx  in  DFX_WIDTH  source id placed in every packet; static
- in_valid  in  NUM_CH  per-channel request valid
- in_ready  out  NUM_CH  per-channel accept; combinational, one-hot or zero
- in_data  in  NUM_CH*DATA_DFX_WIDTH  per-channel payload; channel i at slice i
- in_dst  in  NUM_CH*DFX_WIDTH  per-channel destination
- in_replay  in  NUM_CH  request is a replay
- in_replay_sn  in  NUM_CH*SEQ_NUM_WIDTH  sequence number used on replay
- ack_req  in  1  ACK packet requested; level, held until ack_ready
- ack_dst  in  DFX_WIDTH  ACK destination
- ack_sn  in  SEQ_NUM_WIDTH  sequence number being acknowledged
- ack_ready  out  1  ACK request accepted; combinational
- pkt_valid  out  1  packet valid
- pkt_ready  in  1  fragmenter accepts packet
- pkt_data  out  PKT_WIDTH  {payload, ack, rn, sn, ack_sn, dst, src}; src in the LSBs
- pkt_ch  out  CH_ID_WIDTH  originating channel; 0 for ACK packets
- sn_next  out  NUM_CH*SEQ_NUM_WIDTH  next fresh sequence number per channel

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset values: pkt_valid=0, pkt_data=0, pkt_ch=0, all sn counters=0, round-robin pointer=0.
- Output stage is a single holding register.
  - load_en = !pkt_valid || pkt_ready.
  - When pkt_valid=1 and pkt_ready=0, pkt_data and pkt_ch must hold stable.
- Arbitration is evaluated only when load_en=1. Otherwise in_ready=0 and ack_ready=0.
- Priority order:
  - ack_req is highest: ack_ready=1 and the ACK packet is loaded.
  - Otherwise round-robin over in_valid, starting from the pointer.
  - The granted channel g gets in_ready[g]=1. The pointer moves to (g+1) mod NUM_CH.
  - The pointer is unchanged on ACK grants and idle cycles.
- ACK packet fields: payload=0, ack=1, rn=0, sn=0, ack_sn=ack_sn, dst=ack_dst, src=local_dfx, pkt_ch=0.
- Data packet fields: payload=in_data[g], ack=0, rn=in_replay[g], ack_sn=0, dst=in_dst[g], src=local_dfx, pkt_ch=g.
  - Fresh request (rn=0): sn = sn_cnt[g], then sn_cnt[g] increments mod 2^SEQ_NUM_WIDTH.
  - Replay (rn=1): sn = in_replay_sn[g]; sn_cnt[g] is unchanged.
- On grant, pkt_valid=1 on the next cycle (latency 1).
  - Back-to-back: a handshake and a new grant in the same cycle give no bubble. Sustained rate is 1 packet/cycle.
- If load_en=1 and there is no request, pkt_valid goes to 0 on the next edge.
- sn_next[i] = sn_cnt[i], registered.
- Boundary conditions:
  - sn wraps from 2^SEQ_NUM_WIDTH-1 to 0.
  - All NUM_CH channels valid: each is served once per NUM_CH data grants.
  - ack_req held continuously starves data channels. This is intended; the upstream side rate-limits ACKs.
  - Reset mid-packet drops the held packet, clears counters, and leaves no partial output.
  - NUM_CH=1: the pointer is constant 0.

Test Plan:
- Reset, then a single request on ch0 (in_data=0x5A, dst=2, local_dfx=1), pkt_ready=1 -> one cycle later pkt_valid=1, sn=0, rn=0, ack=0, dst=2, src=1, pkt_ch=0; next request on ch0 gets sn=1.
- ch1 and ch3 requesting continuously, pkt_ready=1 -> grants alternate 1,3,1,3 with no idle cycle; per-channel sn runs 0,1,2,3,0.
- Packet waiting with pkt_ready=0 for 5 cycles while ch2 is valid -> pkt_data stable and in_ready=0 throughout; on the pkt_ready cycle ch2 is accepted and appears on the next cycle.
- ack_req=1 (ack_dst=3, ack_sn=2) together with ch0 valid -> ACK packet first (ack=1, ack_sn=2, payload 0), ch0 packet on the following cycle.
- Replay on ch2 with in_replay_sn=1 after two fresh ch2 packets -> rn=1, sn=1; the next fresh ch2 packet has sn=2.
- Assert rst_n low while pkt_valid=1 and pkt_ready=0 -> pkt_valid=0 and pkt_data=0 immediately, counters 0 after release.
